spi_sclk_gen: RTL and testbench
===============================

Name: spi_sclk_gen

Overview:
- Parametrised SPI serial-clock generator for the SPI controller datapath.
- Produces SCK with programmable divisor, CPOL/CPHA mode and transfer length.
- Emits single-cycle sample/shift strobes for the shift register, plus a done pulse.
- Sits between the controller FSM (start/config) and the SPI pins/shift register.

Parameters:
DIV_W, 8, width of divisor field; SCK period = divisor system clocks
CNT_W, 6, width of bit-count field; max transfer length 2^CNT_W-1 bits

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_cfg_we  in  1  config write strobe, honoured only while idle
i_cfg_div  in  DIV_W  SCK period in i_clk cycles
i_cfg_cpol  in  1  SCK idle level
i_cfg_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
i_cfg_bits  in  CNT_W  bits per transfer
i_start_n  in  1  active-low start request, level-sampled while idle
o_idle  out  1  high when no transfer is running
o_clk  out  1  SCK
o_sample  out  1  1-cycle pulse: shift register samples MISO
o_shift  out  1  1-cycle pulse: shift register drives next MOSI bit
o_done  out  1  1-cycle pulse at transfer end

Behaviour:
- Reset (asynchronous): state IDLE; o_idle=1, o_clk=0, o_sample=o_shift=o_done=0.
- Reset config values: div=2, cpol=0, cpha=0, bits=8.
- Reset mid-transfer aborts immediately. Config returns to reset values.
- Config:
  - Registered on i_cfg_we in IDLE; ignored outside IDLE.
  - Effective divisor: LSB of i_cfg_div is ignored, so odd values round down.
  - Divisor 0 or 1 is treated as 2. Half-period H = div/2.
  - o_clk follows a new cpol in the cycle after the write.
- States: IDLE, RUN.
  - IDLE -> RUN when i_start_n=0, i_cfg_we=0 and bits != 0.
  - Start in the same cycle as i_cfg_we is ignored; the config is taken and start must be re-presented.
  - bits=0: start ignored, block stays IDLE.
- Timing, with T0 = cycle start is sampled:
  - o_idle=0 from T0+1.
  - Half-period counter counts 0..H-1; on terminal count o_clk toggles and the edge counter increments.
  - First SCK edge is visible at T0+H. Edge k is visible at T0+k*H.
  - After edge 2*bits, o_clk is back at cpol.
  - Next cycle: state IDLE, o_idle=1, o_done=1 for one cycle.
  - Busy time = bits*div cycles.
- Edges:
  - Leading edges are the odd-numbered edges (away from cpol); trailing edges are the even-numbered edges.
  - o_sample/o_shift assert in the same cycle o_clk changes.
  - cpha=0: o_sample on leading edges, o_shift on trailing edges except the last one (bits-1 shift pulses).
  - cpha=1: o_shift on leading edges, o_sample on trailing edges (bits of each).
- Back-to-back: if i_start_n stays low, the o_done cycle counts as an IDLE cycle with start sampled. The next transfer begins, with o_idle low again on the following cycle.
- i_start_n during RUN is ignored.
- Edge counter width CNT_W+1; no wrap possible.

Optional Feature:
- Macro SPI_SCLK_GEN_ABORT_EN.
- Defined:
  - Adds input i_abort_n (1 bit, active-low).
  - i_abort_n=0 during RUN returns to IDLE next cycle: o_clk=cpol, o_idle=1, no o_done pulse, no strobes in that cycle.
  - Abort takes priority over a same-cycle edge.
  - Ignored in IDLE.
- Undefined: port absent; RUN always completes.

Test Plan:
- Reset:
  - Hold i_rst_n low 16 cycles, release -> o_idle=1, o_clk=0 and no strobes.
  - Assert reset during RUN -> o_idle=1 asynchronously.
- Mode 0, div=4, bits=8:
  - Start -> o_idle low exactly 32 cycles and o_clk period 4.
  - 8 o_sample pulses on rising edges, 7 o_shift pulses.
  - o_done one cycle, then o_idle=1, o_clk=0.
- cpol=1, cpha=1, div=250, bits=8:
  - o_clk idles 1; busy 2000 cycles.
  - 8 o_shift pulses on falling edges, 8 o_sample pulses on rising edges.
- div=7 and div=0:
  - div=7 -> behaves as div=6 (busy bits*6).
  - div=0 -> period 2 (busy bits*2).
  - Config write during RUN -> ignored; current and next transfer use the old div.
- bits=0 and same-cycle cfg_we/start:
  - bits=0 -> start ignored, o_idle stays 1.
  - Same-cycle write + start -> no transfer.
  - i_start_n held low across o_done -> second transfer starts with no gap beyond the done cycle.
- SPI_SCLK_GEN_ABORT_EN, div=100, bits=16:
  - Abort at cycle 350 -> next cycle o_idle=1, o_clk=cpol, o_done never pulses.
  - New start then completes normally in 1600 cycles.

Source files
------------

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SPI serial-clock generator.
// Produces SCK with a programmable divisor, CPOL/CPHA mode and transfer length.
// It also emits one-cycle sample/shift strobes for the shift register and a
// done pulse at the end of each transfer.
// Optional macro SPI_SCLK_GEN_ABORT_EN adds the active-low i_abort_n input,
// which cancels a running transfer.
module spi_sclk_gen #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cfg_we,
    input  logic [DIV_W-1:0] i_cfg_div,
    input  logic             i_cfg_cpol,
    input  logic             i_cfg_cpha,
    input  logic [CNT_W-1:0] i_cfg_bits,
    input  logic             i_start_n,
`ifdef SPI_SCLK_GEN_ABORT_EN
    input  logic             i_abort_n,
`endif
    output logic             o_idle,
    output logic             o_clk,
    output logic             o_sample,
    output logic             o_shift,
    output logic             o_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;

    // Half-period stored as terminal count (H-1), so divisor 2 -> 0.
    logic [DIV_W-2:0] hlim_q;
    logic             cpol_q, cpha_q;
    logic [CNT_W-1:0] bits_q;

    logic [DIV_W-2:0] hcnt_q, hcnt_d;
    logic [CNT_W:0]   edge_q, edge_d;
    logic             clk_q, clk_d;
    logic             smp_q, smp_d;
    logic             shf_q, shf_d;
    logic             done_q, done_d;

    logic             abort;
    logic             fire;
    logic             tc;
    logic             last;
    logic [CNT_W:0]   edge_nx;
    logic [CNT_W:0]   edge_end;
    logic [DIV_W-2:0] cfg_half;
    logic [DIV_W-2:0] cfg_hlim;

`ifdef SPI_SCLK_GEN_ABORT_EN
    assign abort = ~i_abort_n;
`else
    assign abort = 1'b0;
`endif

    // Divisor LSB dropped; divisors 0 and 1 collapse to a half-period of 1.
    assign cfg_half = i_cfg_div[DIV_W-1:1];
    assign cfg_hlim = (cfg_half == '0) ? '0 : cfg_half - 1'b1;

    assign tc       = (hcnt_q == hlim_q);
    assign edge_nx  = edge_q + 1'b1;
    assign edge_end = {bits_q, 1'b0};
    assign last     = (edge_q == edge_end);

    // Config registers; writes accepted only while idle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hlim_q <= '0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            bits_q <= CNT_W'(8);
        end else if (state_q == IDLE && i_cfg_we) begin
            hlim_q <= cfg_hlim;
            cpol_q <= i_cfg_cpol;
            cpha_q <= i_cfg_cpha;
            bits_q <= i_cfg_bits;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            hcnt_q  <= '0;
            edge_q  <= '0;
            clk_q   <= 1'b0;
            smp_q   <= 1'b0;
            shf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            edge_q  <= edge_d;
            clk_q   <= clk_d;
            smp_q   <= smp_d;
            shf_q   <= shf_d;
            done_q  <= done_d;
        end
    end

    // Next-state: the start cycle already advances the half-period counter,
    // so edge k lands exactly k*H cycles after start is sampled.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        edge_d  = edge_q;
        clk_d   = clk_q;
        smp_d   = 1'b0;
        shf_d   = 1'b0;
        done_d  = 1'b0;
        fire    = 1'b0;

        case (state_q)
            IDLE: begin
                hcnt_d = '0;
                edge_d = '0;
                clk_d  = cpol_q;
                if (i_cfg_we) begin
                    clk_d = i_cfg_cpol;
                end else if (!i_start_n && bits_q != '0) begin
                    state_d = RUN;
                    fire    = 1'b1;
                end
            end
            RUN: begin
                if (abort || last) begin
                    state_d = IDLE;
                    hcnt_d  = '0;
                    edge_d  = '0;
                    clk_d   = cpol_q;
                    done_d  = ~abort;
                end else begin
                    fire = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (fire) begin
            if (tc) begin
                hcnt_d = '0;
                edge_d = edge_nx;
                clk_d  = ~clk_q;
                if (edge_nx[0]) begin
                    // Leading edge.
                    if (cpha_q) shf_d = 1'b1;
                    else        smp_d = 1'b1;
                end else begin
                    // Trailing edge; no shift after the final bit in mode cpha=0.
                    if (cpha_q)                   smp_d = 1'b1;
                    else if (edge_nx != edge_end) shf_d = 1'b1;
                end
            end else begin
                hcnt_d = hcnt_q + 1'b1;
            end
        end
    end

    assign o_idle   = (state_q == IDLE);
    assign o_clk    = clk_q;
    assign o_sample = smp_q;
    assign o_shift  = shf_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// tb_spi_sclk_gen: directed and randomized bench for spi_sclk_gen.
// The reference model tracks time since start and derives SCK level and
// strobes arithmetically from the half-period and edge index.
module tb_spi_sclk_gen;

    localparam int DIV_W = 8;
    localparam int CNT_W = 6;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_cfg_we = 1'b0;
    logic [DIV_W-1:0] i_cfg_div = '0;
    logic             i_cfg_cpol = 1'b0;
    logic             i_cfg_cpha = 1'b0;
    logic [CNT_W-1:0] i_cfg_bits = '0;
    logic             i_start_n = 1'b1;
    logic             i_abort_n = 1'b1;
    logic             o_idle, o_clk, o_sample, o_shift, o_done;

    spi_sclk_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_cfg_we   (i_cfg_we),
        .i_cfg_div  (i_cfg_div),
        .i_cfg_cpol (i_cfg_cpol),
        .i_cfg_cpha (i_cfg_cpha),
        .i_cfg_bits (i_cfg_bits),
        .i_start_n  (i_start_n),
`ifdef SPI_SCLK_GEN_ABORT_EN
        .i_abort_n  (i_abort_n),
`endif
        .o_idle     (o_idle),
        .o_clk      (o_clk),
        .o_sample   (o_sample),
        .o_shift    (o_shift),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model state.
    bit m_run, m_done, m_cpol, m_cpha;
    int m_t, m_h, m_bits;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_done = 0; m_t = 0;
        m_h = 1; m_bits = 8; m_cpol = 0; m_cpha = 0;
    endtask

    // Advance the model by one clock using the inputs presently driven.
    task automatic model_tick();
        bit ab;
        ab = 0;
`ifdef SPI_SCLK_GEN_ABORT_EN
        ab = !i_abort_n;
`endif
        m_done = 0;
        if (m_run) begin
            if (ab) begin
                m_run = 0; m_t = 0;
            end else if (m_t == 2 * m_bits * m_h) begin
                m_run = 0; m_t = 0; m_done = 1;
            end else begin
                m_t++;
            end
        end else if (i_cfg_we) begin
            m_h    = int'(i_cfg_div) / 2;
            if (m_h == 0) m_h = 1;
            m_cpol = i_cfg_cpol;
            m_cpha = i_cfg_cpha;
            m_bits = int'(i_cfg_bits);
        end else if (!i_start_n && m_bits != 0) begin
            m_run = 1; m_t = 1;
        end
    endtask

    task automatic check_outputs();
        int e_idle, e_clk, e_smp, e_shf, e_done, k;
        e_smp = 0; e_shf = 0; e_done = 0;
        if (m_run) begin
            e_idle = 0;
            k      = m_t / m_h;
            e_clk  = int'(m_cpol) ^ (k & 1);
            if (m_t % m_h == 0) begin
                if (k % 2 == 1) begin
                    if (m_cpha) e_shf = 1; else e_smp = 1;
                end else begin
                    if (m_cpha) e_smp = 1;
                    else if (k != 2 * m_bits) e_shf = 1;
                end
            end
        end else begin
            e_idle = 1;
            e_clk  = int'(m_cpol);
            e_done = int'(m_done);
        end
        chk("idle",   int'(o_idle),   e_idle);
        chk("sck",    int'(o_clk),    e_clk);
        chk("sample", int'(o_sample), e_smp);
        chk("shift",  int'(o_shift),  e_shf);
        chk("done",   int'(o_done),   e_done);
    endtask

    // Inputs change only at negedge; outputs checked at negedge.
    task automatic step();
        model_tick();
        @(posedge i_clk);
        @(negedge i_clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic cfg(input int div, input int cpol, input int cpha, input int bits);
        i_cfg_we   = 1'b1;
        i_cfg_div  = div[DIV_W-1:0];
        i_cfg_cpol = cpol[0];
        i_cfg_cpha = cpha[0];
        i_cfg_bits = bits[CNT_W-1:0];
        step();
        i_cfg_we   = 1'b0;
    endtask

    task automatic start_pulse();
        i_start_n = 1'b0;
        step();
        i_start_n = 1'b1;
    endtask

    initial begin
        model_reset();
        // Reset held for 16 cycles.
        i_rst_n = 1'b0;
        repeat (16) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        check_outputs();
        run(2);

        // Mode 0, div 4, 8 bits.
        cfg(4, 0, 0, 8);
        start_pulse();
        run(40);

        // cpol=1, cpha=1, div 250, 8 bits.
        cfg(250, 1, 1, 8);
        start_pulse();
        run(2010);

        // Odd divisor rounds down; zero divisor acts as 2.
        cfg(7, 0, 0, 5);
        start_pulse();
        run(35);
        cfg(0, 0, 1, 6);
        start_pulse();
        run(20);

        // Config write during a transfer is ignored for this and the next.
        cfg(10, 0, 0, 4);
        start_pulse();
        run(5);
        i_cfg_we = 1'b1; i_cfg_div = 8'd2; i_cfg_bits = 6'd1;
        run(10);
        i_cfg_we = 1'b0;
        run(30);
        start_pulse();
        run(45);

        // bits = 0: start ignored.
        cfg(6, 0, 0, 0);
        i_start_n = 1'b0;
        run(10);
        i_start_n = 1'b1;

        // Start in the same cycle as a config write is dropped.
        i_start_n = 1'b0;
        cfg(4, 0, 0, 3);
        i_start_n = 1'b1;
        run(5);

        // Back-to-back transfers with start held low.
        cfg(4, 1, 0, 3);
        i_start_n = 1'b0;
        run(30);
        i_start_n = 1'b1;
        run(15);

        // Asynchronous reset mid-transfer.
        cfg(8, 1, 1, 8);
        start_pulse();
        run(20);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_rst_idle", int'(o_idle), 1);
        chk("async_rst_sck",  int'(o_clk),  0);
        model_reset();
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        check_outputs();
        run(3);

`ifdef SPI_SCLK_GEN_ABORT_EN
        // Abort mid-transfer, then a clean full transfer.
        cfg(100, 0, 0, 16);
        start_pulse();
        run(348);
        i_abort_n = 1'b0;
        step();
        i_abort_n = 1'b1;
        run(5);
        start_pulse();
        run(1605);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            i_cfg_we   = ($urandom % 24) == 0;
            i_cfg_div  = DIV_W'($urandom % 12);
            i_cfg_cpol = 1'($urandom);
            i_cfg_cpha = 1'($urandom);
            i_cfg_bits = CNT_W'($urandom % 7);
            i_start_n  = ($urandom % 3) != 0;
            i_abort_n  = ($urandom % 150) != 0;
            step();
        end
        i_cfg_we  = 1'b0;
        i_start_n = 1'b1;
        i_abort_n = 1'b1;
        run(200);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
